// File: rtl/riscv_imm_pkg.sv
// Shared types for the RISC-V immediate generator: format select codes and
// the occupancy states of its output buffer.
package riscv_imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_PART  = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction handshake plus downstream immediate/target handshake.
// The master drives instructions and consumes results; the slave is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN = riscv_imm_pkg::XLEN_DEFAULT
);
  import riscv_imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  imm_src_e        imm_src;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport master (
    output in_valid, instr, imm_src, pc, flush, out_ready,
    input  in_ready, out_valid, imm_ext, target, illegal
  );

  modport slave (
    input  in_valid, instr, imm_src, pc, flush, out_ready,
    output in_ready, out_valid, imm_ext, target, illegal
  );

endinterface

// File: rtl/imm_decode_core.sv
// Purely combinational immediate decoder: extracts and extends the immediate
// field selected by imm_src from a 32-bit RISC-V instruction word.
module imm_decode_core
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  imm_src_e        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Signed raw fields: a size cast of a signed value replicates instr[31].
  logic signed [11:0] i_field;
  logic signed [11:0] s_field;
  logic signed [12:0] b_field;
  logic signed [20:0] j_field;
  logic signed [31:0] u_field;

  assign i_field = instr[31:20];
  assign s_field = {instr[31:25], instr[11:7]};
  assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign u_field = {instr[31:12], 12'b0};

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (imm_src)
      IMM_I:     imm = XLEN'(i_field);
      IMM_S:     imm = XLEN'(s_field);
      IMM_B:     imm = XLEN'(b_field);
      IMM_J:     imm = XLEN'(j_field);
      IMM_U:     imm = XLEN'(u_field);
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      IMM_RSVD:  illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry output FIFO: decodes the immediate and
// branch/jump target at accept time and presents them one cycle later.
module imm_gen_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  occ_e             occ;
  occ_e             occ_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ready_q;
  logic             has_entry;
  logic             do_accept;
  logic             do_release;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  entry_t           wr_entry;
  entry_t           mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  imm_decode_core #(.XLEN(XLEN)) u_decode (
    .instr   (bus.instr),
    .imm_src (bus.imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Flush dominates: neither side of the handshake completes in a flush cycle.
  assign has_entry  = (occ != OCC_EMPTY);
  assign do_accept  = bus.in_valid && ready_q && !bus.flush;
  assign do_release = has_entry && bus.out_ready && !bus.flush;
  assign bus.in_ready = ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= OCC_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
    end else begin
      occ     <= occ_next;
      ready_q <= (occ_next != OCC_FULL);
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_accept)  wr_ptr <= ptr_inc(wr_ptr);
        if (do_release) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_comb begin
    occ_next = occ;
    if (bus.flush) begin
      occ_next = OCC_EMPTY;
    end else if (do_accept && !do_release) begin
      occ_next = (occ == OCC_EMPTY && DEPTH == 2) ? OCC_PART : OCC_FULL;
    end else if (do_release && !do_accept) begin
      occ_next = (occ == OCC_FULL && DEPTH == 2) ? OCC_PART : OCC_EMPTY;
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.imm_ext   = '0;
    bus.target    = '0;
    bus.illegal   = 1'b0;
    if (has_entry) begin
      bus.out_valid = 1'b1;
      bus.imm_ext   = mem[rd_ptr].imm;
      bus.target    = mem[rd_ptr].target;
      bus.illegal   = mem[rd_ptr].illegal;
    end
  end

  assign wr_entry = '{imm: dec_imm, target: bus.pc + dec_imm, illegal: dec_illegal};

  // NOTE: storage is not reset; outputs are masked by occupancy, so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_accept) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed format vectors, backpressure,
// flush, reset, an XLEN=64/DEPTH=1 instance and randomized traffic vs a queue model.
module tb_imm_gen_pipe;
  import riscv_imm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] instr;
    imm_src_e    src;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .DEPTH(1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  always #5 clk = ~clk;

  // Reference immediate built from the format rules with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input imm_src_e src, input int xlen);
    longint unsigned x;
    longint unsigned raw;
    int              w;
    x   = 64'(ins);
    raw = 64'd0;
    w   = 0;
    case (src)
      IMM_I:     begin raw = x >> 20; w = 12; end
      IMM_S:     begin raw = ((x >> 25) << 5) | ((x >> 7) & 64'h1F); w = 12; end
      IMM_B:     begin
        raw = (((x >> 31) & 64'd1) << 12) | (((x >> 7) & 64'd1) << 11) |
              (((x >> 25) & 64'h3F) << 5) | (((x >> 8) & 64'hF) << 1);
        w = 13;
      end
      IMM_J:     begin
        raw = (((x >> 31) & 64'd1) << 20) | (((x >> 12) & 64'hFF) << 12) |
              (((x >> 20) & 64'd1) << 11) | (((x >> 21) & 64'h3FF) << 1);
        w = 21;
      end
      IMM_U:     begin raw = x & 64'hFFFF_F000; w = 32; end
      IMM_SHAMT: raw = (x >> 20) & ((xlen == 64) ? 64'h3F : 64'h1F);
      IMM_ZIMM:  raw = (x >> 15) & 64'h1F;
      default:   raw = 64'd0;
    endcase
    if (w > 0 && ((raw >> (w - 1)) & 64'd1) == 64'd1) raw = raw - (64'd1 << w);
    if (xlen == 32) raw = raw & 64'h0000_0000_FFFF_FFFF;
    return raw;
  endfunction

  task automatic idle_all();
    b32.in_valid = 1'b0; b32.instr = '0; b32.imm_src = IMM_I; b32.pc = '0;
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.instr = '0; b64.imm_src = IMM_I; b64.pc = '0;
    b64.flush = 1'b0; b64.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal, b64.in_ready, b64.out_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b v=%b imm=%h tgt=%h ill=%b rdy64=%b v64=%b, expected all 0",
               b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal, b64.in_ready, b64.out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({b32.in_ready, b32.out_valid, b64.in_ready, b64.out_valid} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_release: got rdy/v/rdy64/v64=%b expected 1010",
               {b32.in_ready, b32.out_valid, b64.in_ready, b64.out_valid});
    end
  endtask

  task automatic test_directed();
    vec_t v [9];
    v[0] = '{32'hFFF00093, IMM_I,     32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    v[1] = '{32'hFE000EE3, IMM_B,     32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0};
    v[2] = '{32'h0080006F, IMM_J,     32'h0000_0200, 32'h0000_0008, 32'h0000_0208, 1'b0};
    v[3] = '{32'h123450B7, IMM_U,     32'h0000_0000, 32'h1234_5000, 32'h1234_5000, 1'b0};
    v[4] = '{32'hFE112C23, IMM_S,     32'h0000_1000, 32'hFFFF_FFF8, 32'h0000_0FF8, 1'b0};
    v[5] = '{32'h03F00013, IMM_SHAMT, 32'h0000_0010, 32'h0000_001F, 32'h0000_002F, 1'b0};
    v[6] = '{32'h000F8073, IMM_ZIMM,  32'h0000_0020, 32'h0000_001F, 32'h0000_003F, 1'b0};
    v[7] = '{32'hFFFFFFFF, IMM_RSVD,  32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 1'b1};
    v[8] = '{32'h7FF00093, IMM_I,     32'hFFFF_FFF0, 32'h0000_07FF, 32'h0000_07EF, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      b32.in_valid = 1'b1; b32.instr = v[i].instr; b32.imm_src = v[i].src;
      b32.pc = v[i].pc; b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({b32.out_valid, b32.imm_ext, b32.target, b32.illegal} !== {1'b1, v[i].imm, v[i].tgt, v[i].ill}) begin
        bad++;
        $display("FAIL directed[%0d]: got v=%b imm=%h tgt=%h ill=%b expected v=1 imm=%h tgt=%h ill=%b",
                 i, b32.out_valid, b32.imm_ext, b32.target, b32.illegal, v[i].imm, v[i].tgt, v[i].ill);
      end
      @(negedge clk);
      total++;
      if (b32.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL directed_drain[%0d]: got out_valid=%b expected 0", i, b32.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.instr = 32'h00500093; b32.imm_src = IMM_I; b32.pc = 32'h0000_1000;
    @(posedge clk); #1;
    b32.instr = 32'hFFB00093; b32.pc = 32'h0000_2000;
    @(posedge clk); #1;
    b32.instr = 32'h7FF00093; b32.pc = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal} !==
          {1'b0, 1'b1, 32'h0000_0005, 32'h0000_1005, 1'b0}) begin
        bad++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b imm=%h tgt=%h ill=%b expected rdy=0 v=1 imm=00000005 tgt=00001005 ill=0",
                 k, b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal);
      end
    end
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal} !==
        {1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0000_1FFB, 1'b0}) begin
      bad++;
      $display("FAIL release_b: got rdy=%b v=%b imm=%h tgt=%h ill=%b expected rdy=1 v=1 imm=fffffffb tgt=00001ffb ill=0",
               b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal);
    end
    @(negedge clk);
    total++;
    if ({b32.in_ready, b32.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL release_empty: got rdy/v=%b expected 10", {b32.in_ready, b32.out_valid});
    end
  endtask

  task automatic test_flush();
    logic exp_rdy;
    for (int n = 1; n <= 2; n++) begin
      exp_rdy = (n < 2);
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
      for (int j = 0; j < n; j++) begin
        b32.in_valid = 1'b1; b32.instr = 32'h00A00093 + 32'(j << 20); b32.imm_src = IMM_I; b32.pc = '0;
        @(posedge clk); #1;
      end
      b32.flush = 1'b1; b32.in_valid = 1'b1; b32.instr = 32'h00100093;
      @(negedge clk);
      total++;
      if ({b32.in_ready, b32.out_valid} !== {exp_rdy, 1'b1}) begin
        bad++;
        $display("FAIL flush_pre[%0d]: got rdy/v=%b expected %b1", n, {b32.in_ready, b32.out_valid}, exp_rdy);
      end
      @(posedge clk); #1;
      b32.flush = 1'b0; b32.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({b32.out_valid, b32.in_ready, b32.imm_ext, b32.target, b32.illegal} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
        bad++;
        $display("FAIL flush_empty[%0d]: got v=%b rdy=%b imm=%h tgt=%h ill=%b expected v=0 rdy=1 zeros",
                 n, b32.out_valid, b32.in_ready, b32.imm_ext, b32.target, b32.illegal);
      end
      @(negedge clk);
      total++;
      if (b32.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_accept[%0d]: got out_valid=%b expected 0", n, b32.out_valid);
      end
      b32.out_ready = 1'b1;
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [4];
    imm_src_e    src [4];
    logic [63:0] pcs [4];
    logic [63:0] ei  [4];
    logic [63:0] et  [4];
    ins[0] = 32'h800000B7; src[0] = IMM_U;     pcs[0] = 64'h0;     ei[0] = 64'hFFFF_FFFF_8000_0000; et[0] = 64'hFFFF_FFFF_8000_0000;
    ins[1] = 32'h03F00013; src[1] = IMM_SHAMT; pcs[1] = 64'h100;   ei[1] = 64'h3F;                  et[1] = 64'h13F;
    ins[2] = 32'hFFF00093; src[2] = IMM_I;     pcs[2] = 64'h10;    ei[2] = 64'hFFFF_FFFF_FFFF_FFFF; et[2] = 64'hF;
    ins[3] = 32'h0000_0000; src[3] = IMM_RSVD; pcs[3] = 64'h8000;  ei[3] = 64'h0;                   et[3] = 64'h8000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b64.in_valid = 1'b1; b64.instr = ins[i]; b64.imm_src = src[i]; b64.pc = pcs[i]; b64.out_ready = 1'b0;
      @(posedge clk); #1;
      b64.instr = 32'h00000093; b64.imm_src = IMM_I;
      @(negedge clk);
      total++;
      if ({b64.in_ready, b64.out_valid, b64.imm_ext, b64.target, b64.illegal} !== {1'b0, 1'b1, ei[i], et[i], src[i] == IMM_RSVD}) begin
        bad++;
        $display("FAIL x64[%0d]: got rdy=%b v=%b imm=%h tgt=%h ill=%b expected rdy=0 v=1 imm=%h tgt=%h",
                 i, b64.in_ready, b64.out_valid, b64.imm_ext, b64.target, b64.illegal, ei[i], et[i]);
      end
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({b64.out_valid, b64.imm_ext, b64.target} !== {1'b1, ei[i], et[i]}) begin
        bad++;
        $display("FAIL x64_hold[%0d]: got v=%b imm=%h tgt=%h expected v=1 imm=%h tgt=%h",
                 i, b64.out_valid, b64.imm_ext, b64.target, ei[i], et[i]);
      end
      b64.out_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({b64.out_valid, b64.in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL x64_drain[%0d]: got v/rdy=%b expected 01", i, {b64.out_valid, b64.in_ready});
      end
    end
  endtask

  task automatic test_random(input int n);
    exp_t        q [$];
    exp_t        e;
    logic        ev, er, acc, rel;
    logic [63:0] r;
    @(posedge clk); #1;
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) begin
        b32.in_valid  = ($urandom_range(0, 3) != 0);
        b32.instr     = $urandom;
        b32.imm_src   = imm_src_e'(3'($urandom_range(0, 7)));
        b32.pc        = $urandom;
        b32.out_ready = ($urandom_range(0, 2) != 0);
        b32.flush     = ($urandom_range(0, 29) == 0);
      end else begin
        b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.flush = 1'b0;
      end
      @(negedge clk);
      ev = (q.size() > 0);
      er = (q.size() < 2);
      total++;
      if ({b32.out_valid, b32.in_ready} !== {ev, er}) begin
        bad++;
        $display("FAIL rand_flags[%0d]: got v/rdy=%b%b expected %b%b", i, b32.out_valid, b32.in_ready, ev, er);
      end
      if (ev) begin
        total++;
        if ({b32.imm_ext, b32.target, b32.illegal} !== {q[0].imm, q[0].tgt, q[0].ill}) begin
          bad++;
          $display("FAIL rand_data[%0d]: got imm=%h tgt=%h ill=%b expected imm=%h tgt=%h ill=%b",
                   i, b32.imm_ext, b32.target, b32.illegal, q[0].imm, q[0].tgt, q[0].ill);
        end
      end
      acc = b32.in_valid && er && !b32.flush;
      rel = ev && b32.out_ready && !b32.flush;
      if (b32.flush) begin
        q.delete();
      end else begin
        if (rel) void'(q.pop_front());
        if (acc) begin
          r     = ref_imm(b32.instr, b32.imm_src, 32);
          e.imm = r[31:0];
          e.tgt = b32.pc + r[31:0];
          e.ill = (b32.imm_src == IMM_RSVD);
          q.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.instr = 32'hFE000EE3; b32.imm_src = IMM_B; b32.pc = 32'h100;
    b64.out_ready = 1'b0; b64.in_valid = 1'b1; b64.instr = 32'h123450B7; b64.imm_src = IMM_U; b64.pc = '0;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({b32.out_valid, b32.in_ready, b64.out_valid} !== 3'b101) begin
      bad++;
      $display("FAIL midreset_pre: got v/rdy/v64=%b expected 101", {b32.out_valid, b32.in_ready, b64.out_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ((|{b32.in_ready, b32.out_valid, b32.imm_ext, b32.target, b32.illegal,
           b64.in_ready, b64.out_valid, b64.imm_ext, b64.target, b64.illegal}) !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got v=%b imm=%h tgt=%h v64=%b imm64=%h expected all outputs 0",
               b32.out_valid, b32.imm_ext, b32.target, b64.out_valid, b64.imm_ext);
    end
    @(negedge clk);
    idle_all();
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL midreset_after: got v/rdy/v64/rdy64=%b expected 0101",
               {b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_xlen64();
    test_random(400);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
